ifetch_unit: RTL and testbench

- Instruction-fetch front end that sits between the PC unit and instruction memory.
- Consumes the current `pc` and drives a req/ack read handshake to instruction memory.
- Presents the fetched instruction, with its PC, to decode.
- Tells control when the PC must not advance, and when a fetch fault requires an ILLOP redirect.

---
 rtl/ifetch_unit_pkg.sv | 27 ++
 rtl/ifetch_unit_if.sv | 22 ++
 rtl/ifetch_unit.sv | 103 ++++++++++
 tb/tb_ifetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end: fetch FSM encoding,
// the NOP presented while no instruction is held, and the fixed PC vectors.
package ifetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 30;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h83FF_F800;  // ADD(R31,R31,R31)
  localparam logic [XLEN-1:0] RESET         = 32'h8000_0000;
  localparam logic [XLEN-1:0] ILLOP         = 32'h8000_0004;
  localparam logic [XLEN-1:0] XADR          = 32'h8000_0008;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DROP  = 3'd2,
    ST_HAVE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // The supervisor bit can be stripped so both modes share one physical space.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [XLEN-1:0] pc_v,
                                                  input bit mask_super);
    return mask_super ? {1'b0, pc_v[30:2]} : pc_v[31:2];
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// Handshake: imem_req, once raised, holds with a stable imem_addr until the cycle
// imem_ack=1; imem_rdata/imem_err are meaningful only in that ack cycle.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_rdata;
  logic              imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata, imem_err
  );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch front end: issues one imem read per instruction, presents the result to
// decode, stalls the PC while no instruction is held and flags fetch faults.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF,
  parameter bit          MASK_SUPER = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [XLEN-1:0]     pc,
  input  logic                redirect,
  input  logic                hold,
  ifetch_unit_if.master       imem,
  output logic [XLEN-1:0]     instr,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instr_pc,
  output logic                pc_stall,
  output logic                fetch_fault,
  output state_e              dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] live_addr;

  assign live_addr = word_addr(pc, MASK_SUPER);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = addr_q;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = live_addr;
        // pc is stalled while in REQ, so re-capturing every cycle equals capturing once.
        addr_d         = live_addr;
        if (imem.imem_ack) begin
          if (redirect) begin
            state_d = ST_REQ;
          end else if (imem.imem_err) begin
            state_d = ST_FAULT;
          end else begin
            instr_d    = imem.imem_rdata;
            instr_pc_d = pc;
            state_d    = ST_HAVE;
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end

      // The stale request must complete; pc already holds the redirect target.
      ST_DROP: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) state_d = ST_REQ;
      end

      ST_HAVE: begin
        if (redirect)  state_d = ST_REQ;
        else if (hold) state_d = ST_HAVE;
        else           state_d = ST_REQ;
      end

      ST_FAULT: begin
        if (redirect) state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_valid = (state_q == ST_HAVE);
  assign instr       = instr_valid ? instr_q : NOP_INSTR;
  assign instr_pc    = instr_pc_q;
  assign pc_stall    = !instr_valid;
  assign fetch_fault = (state_q == ST_FAULT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stimulus pushes hand-computed expectations,
// monitors pop and compare whenever the DUT presents an instruction or an acked request.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h83FF_F800;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc;
  logic        redirect;
  logic        hold;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        pc_stall;
  logic        fetch_fault;
  state_e      dbg_state;

  ifetch_unit_if bus ();

  ifetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc          (pc),
    .redirect    (redirect),
    .hold        (hold),
    .imem        (bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .pc_stall    (pc_stall),
    .fetch_fault (fetch_fault),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];       // {instr_pc, instr} per delivered instruction
  logic [29:0] exp_addr_q[$];  // address of each acked request
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (reset_n && instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("instr_unexpected", {instr_pc, instr}, 64'h0);
      else                   chk("instr_delivered", {instr_pc, instr}, exp_q.pop_front());
    end
    if (!instr_valid) chk("instr_nop_when_invalid", instr, NOP);
    if (reset_n && bus.imem_req && bus.imem_ack) begin
      if (exp_addr_q.size() == 0) chk("ack_unexpected", bus.imem_addr, 30'h3FFF_FFFF);
      else                        chk("ack_addr", bus.imem_addr, exp_addr_q.pop_front());
    end
    prev_valid = instr_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   bus.imem_req, 1'b0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_ipc"},   instr_pc, 32'h0);
    chk({tag, "_fault"}, fetch_fault, 1'b0);
    chk({tag, "_stall"}, pc_stall, 1'b1);
    chk({tag, "_addr"},  bus.imem_addr, 30'h0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Entered just after the edge into REQ with pc = pc_v; leaves after the HAVE-cycle checks.
  task automatic do_fetch(input logic [31:0] pc_v, input logic [29:0] a,
                          input logic [31:0] data, input int waits);
    exp_addr_q.push_back(a);
    exp_q.push_back({pc_v, data});
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      @(negedge clock);
      chk("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, a);
      chk("wait_valid", instr_valid, 1'b0);
      cyc();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    bus.imem_err   = 1'b0;
    @(negedge clock);
    chk("ack_req", bus.imem_req, 1'b1);
    chk("ack_addr_direct", bus.imem_addr, a);
    chk("ack_stall", pc_stall, 1'b1);
    chk("ack_fault", fetch_fault, 1'b0);
    cyc();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    @(negedge clock);
    chk("have_valid", instr_valid, 1'b1);
    chk("have_stall", pc_stall, 1'b0);
    chk("have_req", bus.imem_req, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    pc             = RESET;
    redirect       = 1'b0;
    hold           = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.imem_err   = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("rst");

    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_state", dbg_state, ST_IDLE);
    chk("idle_req", bus.imem_req, 1'b0);

    // Supervisor PC, ack two cycles after request.
    cyc();
    do_fetch(32'h8000_0000, 30'h0, 32'h1234_5678, 2);

    // Zero-wait memory, sequential PCs.
    cyc(); pc = 32'h0; do_fetch(32'h0, 30'h0, 32'hA000_0001, 0);
    cyc(); pc = 32'h4; do_fetch(32'h4, 30'h1, 32'hA000_0002, 0);
    cyc(); pc = 32'h8; do_fetch(32'h8, 30'h2, 32'hA000_0003, 0);

    // Decode holds the instruction.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clock);
      chk("hold_instr", instr, 32'hA000_0003);
      chk("hold_ipc", instr_pc, 32'h8);
      chk("hold_req", bus.imem_req, 1'b0);
      chk("hold_stall", pc_stall, 1'b0);
    end
    hold = 1'b0;
    cyc(); pc = 32'hC; do_fetch(32'hC, 30'h3, 32'hA000_0004, 0);

    // Ack coinciding with redirect: data discarded, stay in REQ.
    cyc();
    pc             = 32'h8000_0020;
    redirect       = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    exp_addr_q.push_back(30'h8);
    cyc();
    redirect     = 1'b0;
    bus.imem_ack = 1'b0;
    pc           = 32'h8000_0040;
    do_fetch(32'h8000_0040, 30'h10, 32'hA000_0005, 1);

    // Redirect without ack in REQ -> DROP keeps the old address until ack.
    cyc();
    pc       = 32'h14;
    redirect = 1'b1;
    @(negedge clock);
    chk("drop_entry_addr", bus.imem_addr, 30'h5);
    cyc();
    redirect = 1'b0;
    pc       = XADR;
    exp_addr_q.push_back(30'h5);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_err   = 1'b1;
      end
      @(negedge clock);
      chk("drop_state", dbg_state, ST_DROP);
      chk("drop_addr", bus.imem_addr, 30'h5);
      chk("drop_req", bus.imem_req, 1'b1);
      chk("drop_valid", instr_valid, 1'b0);
      cyc();
    end
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
    do_fetch(XADR, 30'h2, 32'hA000_0006, 0);

    // User-mode fetch error.
    cyc();
    pc           = 32'h100;
    bus.imem_ack = 1'b1;
    bus.imem_err = 1'b1;
    exp_addr_q.push_back(30'h40);
    cyc();
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("fault_flag", fetch_fault, 1'b1);
      chk("fault_instr", instr, NOP);
      chk("fault_req", bus.imem_req, 1'b0);
      chk("fault_stall", pc_stall, 1'b1);
      if (i == 2) redirect = 1'b1;
      cyc();
    end
    redirect = 1'b0;
    pc       = ILLOP;
    do_fetch(ILLOP, 30'h1, 32'hA000_0007, 0);

    // Supervisor-mode fetch error.
    cyc();
    pc           = 32'h8000_0200;
    bus.imem_ack = 1'b1;
    bus.imem_err = 1'b1;
    exp_addr_q.push_back(30'h80);
    cyc();
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
    @(negedge clock);
    chk("sup_fault_flag", fetch_fault, 1'b1);
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    pc       = ILLOP;
    do_fetch(ILLOP, 30'h1, 32'hA000_0008, 0);

    // Asynchronous reset in the middle of DROP.
    cyc();
    pc       = 32'h30;
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    pc       = XADR;
    @(negedge clock);
    chk("pre_rst_state", dbg_state, ST_DROP);
    chk("pre_rst_addr", bus.imem_addr, 30'hC);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    pc      = RESET;
    @(negedge clock);
    chk("rel_idle_state", dbg_state, ST_IDLE);
    chk("rel_idle_req", bus.imem_req, 1'b0);
    cyc();
    do_fetch(RESET, 30'h0, 32'hA000_0009, 1);

    cyc();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_addr_q_drained", exp_addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
